// File: rtl/iob_regbank_rsp.sv
// iob_regbank_rsp: IOb native-interface responder wrapping a bank of
// software-visible registers. The CPU writes with byte strobes and reads
// with a fixed, programmable latency; hardware logic observes every register
// on regs_o and can overwrite any of them through hw_en_i/hw_data_i.
// A read returns a snapshot taken at the accepting edge, so register updates
// during the wait window never disturb the response in flight.

module iob_regbank_rsp #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 5,
  parameter int                N_REGS   = 8,
  parameter logic [DATA_W-1:0] RST_VAL  = '0,
  parameter int                WAIT_CYC = 0
) (
  input  logic                     clk_i,
  input  logic                     cke_i,
  input  logic                     rst_i,

  input  logic                     iob_valid_i,
  input  logic [ADDR_W-1:0]        iob_addr_i,
  input  logic [DATA_W-1:0]        iob_wdata_i,
  input  logic [DATA_W/8-1:0]      iob_wstrb_i,
  output logic                     iob_ready_o,
  output logic                     iob_rvalid_o,
  output logic [DATA_W-1:0]        iob_rdata_o,

  input  logic [N_REGS-1:0]        hw_en_i,
  input  logic [N_REGS*DATA_W-1:0] hw_data_i,
  output logic [N_REGS*DATA_W-1:0] regs_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = ADDR_W - 2;
  localparam int CNT_W  = 4;

  // Wait-counter reload: the WAIT state lasts exactly WAIT_CYC cycles,
  // counting down to zero inclusive.
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_CYC > 0) ? CNT_W'(WAIT_CYC - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  rdata_q;

  logic [IDX_W-1:0]   word_idx;
  logic               idx_ok;
  logic               is_write;
  logic               accept;
  logic               rd_acc;
  logic               wr_acc;
  logic [DATA_W-1:0]  rd_word;

  // Byte-offset bits carry no meaning for word-aligned registers.
  logic               unused_addr_lsb;
  assign unused_addr_lsb = ^iob_addr_i[1:0];

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  assign word_idx = iob_addr_i[ADDR_W-1:2];
  assign idx_ok   = (int'(word_idx) < N_REGS);
  assign is_write = |iob_wstrb_i;

  // Ready depends on registered state only, so the handshake has no
  // combinational path back from iob_valid_i.
  assign iob_ready_o  = (state_q != ST_WAIT);
  assign iob_rvalid_o = (state_q == ST_RESP);
  assign iob_rdata_o  = rdata_q;

  assign accept = iob_valid_i & iob_ready_o;
  assign rd_acc = accept & ~is_write;
  assign wr_acc = accept & is_write & idx_ok;

  // Snapshot source for reads: addressed register, or zero when out of range.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    rd_word = '0;
    for (int k = 0; k < N_REGS; k++) begin
      if (idx_ok && (word_idx == IDX_W'(k))) begin
        rd_word = regs_o[k*DATA_W +: DATA_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response state machine
  // ---------------------------------------------------------------------------

  // Next-state logic: IDLE and RESP share the accept rules; WAIT counts down.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE, ST_RESP: begin
        if (rd_acc) begin
          if (WAIT_CYC == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and read-data registers; reset overrides the clock enable.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else if (cke_i) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (rd_acc) begin
        rdata_q <= rd_word;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Register bank
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < N_REGS; k++) begin : g_reg
    logic              bus_sel;
    logic [DATA_W-1:0] reg_q;
    logic [DATA_W-1:0] reg_d;

    assign bus_sel = wr_acc && (word_idx == IDX_W'(k));

    // Per-byte merge: strobed bus bytes win, then hardware data, else hold.
    always_comb begin
      reg_d = reg_q;
      for (int b = 0; b < STRB_W; b++) begin
        if (bus_sel && iob_wstrb_i[b]) begin
          reg_d[b*8 +: 8] = iob_wdata_i[b*8 +: 8];
        end else if (hw_en_i[k]) begin
          reg_d[b*8 +: 8] = hw_data_i[k*DATA_W + b*8 +: 8];
        end
      end
    end

    // Register cell with reset and clock enable.
    always_ff @(posedge clk_i) begin
      // NOTE: each bank entry is reset because software must read RST_VAL after reset; this is a register file, not a RAM.
      if (rst_i) begin
        reg_q <= RST_VAL;
      end else if (cke_i) begin
        reg_q <= reg_d;
      end
    end

    assign regs_o[k*DATA_W +: DATA_W] = reg_q;
  end

endmodule

// File: tb/tb_iob_regbank_rsp.sv
// tb_iob_regbank_rsp: two responders (WAIT_CYC = 0 and 3) share one stimulus
// stream. A transaction-level model per instance predicts outputs each cycle;
// directed sequences pin the model with literal values, then random traffic.

module tb_iob_regbank_rsp;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int NR = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              cke, rst, valid;
  logic [AW-1:0]     addr;
  logic [DW-1:0]     wdata;
  logic [DW/8-1:0]   wstrb;
  logic [NR-1:0]     hw_en;
  logic [NR*DW-1:0]  hw_data;

  logic              ready   [2];
  logic              rvalid  [2];
  logic [DW-1:0]     rdata   [2];
  logic [NR*DW-1:0]  regs    [2];

  iob_regbank_rsp #(.DATA_W(DW), .ADDR_W(AW), .N_REGS(NR), .WAIT_CYC(0)) dut0 (
    .clk_i(clk), .cke_i(cke), .rst_i(rst),
    .iob_valid_i(valid), .iob_addr_i(addr), .iob_wdata_i(wdata), .iob_wstrb_i(wstrb),
    .iob_ready_o(ready[0]), .iob_rvalid_o(rvalid[0]), .iob_rdata_o(rdata[0]),
    .hw_en_i(hw_en), .hw_data_i(hw_data), .regs_o(regs[0])
  );

  iob_regbank_rsp #(.DATA_W(DW), .ADDR_W(AW), .N_REGS(NR), .WAIT_CYC(3)) dut1 (
    .clk_i(clk), .cke_i(cke), .rst_i(rst),
    .iob_valid_i(valid), .iob_addr_i(addr), .iob_wdata_i(wdata), .iob_wstrb_i(wstrb),
    .iob_ready_o(ready[1]), .iob_rvalid_o(rvalid[1]), .iob_rdata_o(rdata[1]),
    .hw_en_i(hw_en), .hw_data_i(hw_data), .regs_o(regs[1])
  );

  int n_vec = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [NR*DW-1:0] act,
                       input logic [NR*DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: t_m = enabled edges left until the response cycle
  // (-1 = nothing outstanding). Ready whenever t_m <= 0, rvalid when t_m == 0.
  // ---------------------------------------------------------------------------
  int          t_m     [2];
  logic [DW-1:0] regs_m  [2][NR];
  logic [DW-1:0] rdata_m [2];

  function automatic int wait_of(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  always @(posedge clk) begin : model
    int idx;
    bit acc;
    logic [DW-1:0] nxt [NR];
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        t_m[i]     = -1;
        rdata_m[i] = '0;
        for (int k = 0; k < NR; k++) regs_m[i][k] = '0;
      end else if (cke) begin
        idx = int'(addr[AW-1:2]);
        acc = valid && (t_m[i] <= 0);
        for (int k = 0; k < NR; k++)
          nxt[k] = hw_en[k] ? hw_data[k*DW +: DW] : regs_m[i][k];
        if (acc && wstrb != '0 && idx < NR)
          for (int b = 0; b < DW/8; b++)
            if (wstrb[b]) nxt[idx][b*8 +: 8] = wdata[b*8 +: 8];
        if (acc && wstrb == '0) begin
          rdata_m[i] = (idx < NR) ? regs_m[i][idx] : '0;
          t_m[i]     = wait_of(i);
        end else if (t_m[i] >= 0) begin
          t_m[i] = t_m[i] - 1;
        end
        for (int k = 0; k < NR; k++) regs_m[i][k] = nxt[k];
      end
    end
  end

  // Compare every cycle on the falling edge, away from the active edge.
  always @(negedge clk) begin : monitor
    logic [NR*DW-1:0] ev;
    if (mon_en) begin
      for (int i = 0; i < 2; i++) begin
        for (int k = 0; k < NR; k++) ev[k*DW +: DW] = regs_m[i][k];
        check($sformatf("ready[%0d]", i),  ready[i],  t_m[i] <= 0);
        check($sformatf("rvalid[%0d]", i), rvalid[i], t_m[i] == 0);
        check($sformatf("rdata[%0d]", i),  rdata[i],  rdata_m[i]);
        check($sformatf("regs[%0d]", i),   regs[i],   ev);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [DW/8-1:0] s);
    valid = 1'b1; addr = a; wdata = d; wstrb = s;
    cyc();
    valid = 1'b0; wstrb = '0;
  endtask

  logic [NR*DW-1:0] exp_bank;

  initial begin
    cke = 1'b1; rst = 1'b1; valid = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    hw_en = '0; hw_data = '0;

    // Reset: two cycles with rst high.
    cyc();
    mon_en = 1'b1;
    cyc();
    for (int i = 0; i < 2; i++) begin
      check("rst_regs",   regs[i],   '0);
      check("rst_ready",  ready[i],  1'b1);
      check("rst_rvalid", rvalid[i], 1'b0);
      check("rst_rdata",  rdata[i],  '0);
    end
    rst = 1'b0;

    // Full write then single-byte write to reg2, then read it back.
    bus_write(6'h08, 32'hDEADBEEF, 4'hF);
    bus_write(6'h08, 32'h00001200, 4'h2);
    check("model_reg2", regs_m[0][2], 32'hDEAD12EF);
    check("reg2_w0", regs[0][2*DW +: DW], 32'hDEAD12EF);
    check("reg2_w3", regs[1][2*DW +: DW], 32'hDEAD12EF);
    valid = 1'b1; addr = 6'h08; wstrb = '0;
    cyc();
    valid = 1'b0;
    check("rd2_rvalid_w0", rvalid[0], 1'b1);
    check("rd2_rdata_w0",  rdata[0],  32'hDEAD12EF);
    check("rd2_ready_w3",  ready[1],  1'b0);
    cyc();
    check("rd2_rvalid_end_w0", rvalid[0], 1'b0);
    cyc(); cyc();
    check("rd2_rvalid_w3", rvalid[1], 1'b1);
    check("rd2_rdata_w3",  rdata[1],  32'hDEAD12EF);
    cyc();

    // Snapshot read of reg1 while hardware overwrites it one cycle later.
    bus_write(6'h04, 32'h00000011, 4'hF);
    valid = 1'b1; addr = 6'h04; wstrb = '0;
    cyc();
    valid = 1'b0; hw_en = 8'h02; hw_data[1*DW +: DW] = 32'h00000022;
    check("snap_ready1_w3", ready[1], 1'b0);
    check("snap_rvalid_w0", rvalid[0], 1'b1);
    check("snap_rdata_w0",  rdata[0],  32'h00000011);
    cyc();
    hw_en = '0; hw_data = '0;
    check("snap_ready2_w3", ready[1], 1'b0);
    check("snap_hw_w3", regs[1][1*DW +: DW], 32'h00000022);
    cyc();
    check("snap_ready3_w3", ready[1], 1'b0);
    cyc();
    check("snap_rvalid_w3", rvalid[1], 1'b1);
    check("snap_rdata_w3",  rdata[1],  32'h00000011);
    check("snap_ready4_w3", ready[1],  1'b1);
    cyc();

    // Bus byte write and hardware update on reg3 in the same edge.
    valid = 1'b1; addr = 6'h0C; wdata = 32'h000000AA; wstrb = 4'h1;
    hw_en = 8'h08; hw_data[3*DW +: DW] = 32'h12345678;
    cyc();
    valid = 1'b0; wstrb = '0; hw_en = '0; hw_data = '0;
    check("merge_w0", regs[0][3*DW +: DW], 32'h123456AA);
    check("merge_w3", regs[1][3*DW +: DW], 32'h123456AA);

    // Out-of-range read returns zero with normal timing.
    valid = 1'b1; addr = 6'h3C; wstrb = '0;
    cyc();
    valid = 1'b0;
    check("oor_rvalid_w0", rvalid[0], 1'b1);
    check("oor_rdata_w0",  rdata[0],  '0);
    cyc(); cyc(); cyc();
    check("oor_rvalid_w3", rvalid[1], 1'b1);
    check("oor_rdata_w3",  rdata[1],  '0);
    cyc();

    // Out-of-range write changes nothing.
    bus_write(6'h3C, 32'hFFFFFFFF, 4'hF);
    exp_bank = {128'h0, 32'h123456AA, 32'hDEAD12EF, 32'h00000022, 32'h00000000};
    check("oor_write_w0", regs[0], exp_bank);
    check("oor_write_w3", regs[1], exp_bank);

    // Back-to-back reads with valid held, then a clock-enable freeze.
    bus_write(6'h00, 32'hA5A55A5A, 4'hF);
    valid = 1'b1; addr = 6'h00; wstrb = '0;
    cyc();
    check("b2b_rvalid0_w0", rvalid[0], 1'b1);
    check("b2b_rdata0_w0",  rdata[0],  32'hA5A55A5A);
    addr = 6'h04;
    cyc();
    check("b2b_rvalid1_w0", rvalid[0], 1'b1);
    check("b2b_rdata1_w0",  rdata[0],  32'h00000022);
    valid = 1'b0; cke = 1'b0;
    for (int n = 0; n < 2; n++) begin
      cyc();
      check("frz_rvalid_w0", rvalid[0], 1'b1);
      check("frz_rdata_w0",  rdata[0],  32'h00000022);
      check("frz_ready_w0",  ready[0],  1'b1);
      check("frz_ready_w3",  ready[1],  1'b0);
    end
    cke = 1'b1;
    cyc();
    check("unfrz_rvalid_w0", rvalid[0], 1'b0);
    repeat (5) cyc();

    // Reset in the middle of a waited read aborts it.
    valid = 1'b1; addr = 6'h08; wstrb = '0;
    cyc();
    valid = 1'b0;
    cyc();
    check("abort_in_wait_w3", ready[1], 1'b0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("abort_regs_w3",  regs[1],  '0);
    check("abort_rdata_w3", rdata[1], '0);
    for (int n = 0; n < 6; n++) begin
      check("abort_ready_w3",  ready[1],  1'b1);
      check("abort_rvalid_w3", rvalid[1], 1'b0);
      cyc();
    end

    // Random traffic against the model.
    repeat (3000) begin
      rst   = ($urandom_range(0, 199) == 0);
      cke   = ($urandom_range(0, 9) != 0);
      valid = ($urandom_range(0, 1) == 1);
      addr  = AW'($urandom_range(0, (1 << AW) - 1));
      wdata = $urandom;
      wstrb = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      hw_en = NR'($urandom) & NR'($urandom) & NR'($urandom);
      for (int k = 0; k < NR; k++) hw_data[k*DW +: DW] = $urandom;
      cyc();
    end

    rst = 1'b0; cke = 1'b1; valid = 1'b0; wstrb = '0; hw_en = '0;
    repeat (6) cyc();
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
